// File: rtl/lcd_rx_pkg.sv
// Shared FSM type, CRC constants and helpers for the LCD timing receiver.
package lcd_rx_pkg;

    localparam int unsigned CW_DEFAULT = 11;
    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    typedef enum logic [1:0] {StSearch, StMeasure, StCheck, StLocked} rx_state_e;

    // One 16-bit data word folded into the CRC, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/lcd_frame_crc16.sv
// Running CRC-16-CCITT over one pixel word per enabled cycle; init restarts the frame.
module lcd_frame_crc16
    import lcd_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    logic [15:0] base;

    // A pixel on the init cycle belongs to the new frame.
    assign base = init ? CRC_INIT : crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(base, data);
        end else if (init) begin
            crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/lcd_timing_rx.sv
// Parallel RGB LCD timing monitor: pixel coordinates, frame geometry and lock detection.
// Optional per-frame pixel CRC is built when LCD_RX_FRAME_CRC_EN is defined.
module lcd_timing_rx
    import lcd_rx_pkg::*;
#(
    parameter int unsigned CW              = CW_DEFAULT,
    parameter int unsigned LOCK_FRAMES     = 2,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          HSYNC,
    input  logic          VSYNC,
    input  logic          DE,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          PIX_VALID,
    output logic          FRAME_START,
    output logic [CW-1:0] ACT_W,
    output logic [CW-1:0] ACT_H,
    output logic [CW-1:0] H_TOTAL,
    output logic [CW-1:0] V_TOTAL,
    output logic          LOCKED,
    output logic          ERR
`ifdef LCD_RX_FRAME_CRC_EN
    ,
    input  logic [4:0]    R,
    input  logic [5:0]    G,
    input  logic [4:0]    B,
    output logic [15:0]   FRAME_CRC,
    output logic          CRC_VALID
`endif
);

    localparam logic [CW-1:0] CMAX = '1;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    rx_state_e     state;
    logic [7:0]    match_cnt, match_nx;
    logic          hs_now, vs_now, hs_prev, vs_prev, de_prev;
    logic          hs_rise, vs_rise, de_rise, de_fall;
    logic [CW-1:0] h_cnt, v_cnt, row, lines, cur_w, cur_h;
    logic [CW-1:0] line_w, cur_w_nx, cur_h_nx;
    logic          sat, frame_eq, line_bad, frame_evt, store_cand;

    assign hs_now  = HSYNC ^ SYNC_ACTIVE_LOW;
    assign vs_now  = VSYNC ^ SYNC_ACTIVE_LOW;
    assign hs_rise = hs_now & ~hs_prev;
    assign vs_rise = vs_now & ~vs_prev;
    assign de_rise = DE & ~de_prev;
    assign de_fall = ~DE & de_prev;

    // On the DE fall cycle X still holds the last column of the line.
    assign line_w   = inc(X);
    assign cur_w_nx = de_fall ? line_w : cur_w;
    assign cur_h_nx = hs_rise ? h_cnt : cur_h;
    assign match_nx = match_cnt + 8'd1;

    assign sat = (h_cnt == CMAX) | (v_cnt == CMAX) | (X == CMAX) | (row == CMAX) |
                 (lines == CMAX);
    assign frame_eq = (cur_w_nx == ACT_W) && (lines == ACT_H) &&
                      (cur_h_nx == H_TOTAL) && (v_cnt == V_TOTAL);
    assign line_bad = (de_fall && (line_w != ACT_W)) || (hs_rise && (h_cnt != H_TOTAL));

    assign frame_evt  = vs_rise & ~sat & ~((state == StLocked) & line_bad);
    assign store_cand = frame_evt & ((state == StMeasure) |
                        (((state == StCheck) | (state == StLocked)) & ~frame_eq));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            de_prev     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            row         <= '0;
            lines       <= '0;
            cur_w       <= '0;
            cur_h       <= '0;
            X           <= '0;
            Y           <= '0;
            PIX_VALID   <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            hs_prev     <= hs_now;
            vs_prev     <= vs_now;
            de_prev     <= DE;
            h_cnt       <= hs_rise ? CW'(1) : inc(h_cnt);
            cur_h       <= cur_h_nx;
            cur_w       <= cur_w_nx;
            PIX_VALID   <= DE;
            FRAME_START <= vs_rise;
            if (vs_rise) begin
                v_cnt <= CW'(1);
                lines <= {{(CW-1){1'b0}}, de_rise};
                row   <= '0;
            end else begin
                if (hs_rise) v_cnt <= inc(v_cnt);
                if (de_rise) lines <= inc(lines);
                if (de_fall) row <= inc(row);
            end
            if (DE) begin
                X <= de_rise ? '0 : inc(X);
                Y <= vs_rise ? '0 : row;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= StSearch;
            match_cnt <= '0;
            LOCKED    <= 1'b0;
            ERR       <= 1'b0;
            ACT_W     <= '0;
            ACT_H     <= '0;
            H_TOTAL   <= '0;
            V_TOTAL   <= '0;
        end else begin
            ERR <= 1'b0;
            if (store_cand) begin
                ACT_W   <= cur_w_nx;
                ACT_H   <= lines;
                H_TOTAL <= cur_h_nx;
                V_TOTAL <= v_cnt;
            end
            if (sat) begin
                state  <= StSearch;
                LOCKED <= 1'b0;
                ERR    <= LOCKED;
            end else if ((state == StLocked) && line_bad) begin
                ERR    <= 1'b1;
                LOCKED <= 1'b0;
                state  <= StMeasure;
            end else if (vs_rise) begin
                unique case (state)
                    StSearch: state <= StMeasure;
                    StMeasure: begin
                        match_cnt <= '0;
                        state     <= StCheck;
                    end
                    StCheck: begin
                        if (frame_eq) begin
                            match_cnt <= match_nx;
                            if (32'(match_nx) >= LOCK_FRAMES) begin
                                state  <= StLocked;
                                LOCKED <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    StLocked: begin
                        if (!frame_eq) begin
                            ERR       <= 1'b1;
                            LOCKED    <= 1'b0;
                            match_cnt <= '0;
                            state     <= StCheck;
                        end
                    end
                    default: state <= StSearch;
                endcase
            end
        end
    end

`ifdef LCD_RX_FRAME_CRC_EN
    logic [15:0] crc_cur;
    logic        crc_armed;

    lcd_frame_crc16 u_crc (
        .clk  (CLK),
        .rst_n(nRST),
        .init (vs_rise),
        .en   (DE),
        .data ({R, G, B}),
        .crc  (crc_cur)
    );

    // The frame cut short by reset release is never reported.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            FRAME_CRC <= '0;
            CRC_VALID <= 1'b0;
            crc_armed <= 1'b0;
        end else begin
            CRC_VALID <= vs_rise & crc_armed;
            if (vs_rise) begin
                crc_armed <= 1'b1;
                if (crc_armed) FRAME_CRC <= crc_cur;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lcd_timing_rx.sv
// Self-checking bench for lcd_timing_rx on a reduced 8x6 active / 12x9 total raster.
module tb_lcd_timing_rx;
    import lcd_rx_pkg::*;

    localparam int CW = 11;

    logic          CLK = 1'b0;
    logic          nRST, HSYNC, VSYNC, DE;
    logic [CW-1:0] X, Y, ACT_W, ACT_H, H_TOTAL, V_TOTAL;
    logic          PIX_VALID, FRAME_START, LOCKED, ERR;
`ifdef LCD_RX_FRAME_CRC_EN
    logic [4:0]    R, B;
    logic [5:0]    G;
    logic [15:0]   FRAME_CRC, pix, m_crc, m_frame, const_crc;
    logic          CRC_VALID;
    bit            m_armed, exp_valid;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    lcd_timing_rx dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .HSYNC      (HSYNC),
        .VSYNC      (VSYNC),
        .DE         (DE),
        .X          (X),
        .Y          (Y),
        .PIX_VALID  (PIX_VALID),
        .FRAME_START(FRAME_START),
        .ACT_W      (ACT_W),
        .ACT_H      (ACT_H),
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL),
        .LOCKED     (LOCKED),
        .ERR        (ERR)
`ifdef LCD_RX_FRAME_CRC_EN
        ,
        .R          (R),
        .G          (G),
        .B          (B),
        .FRAME_CRC  (FRAME_CRC),
        .CRC_VALID  (CRC_VALID)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int run; int f; int l; int c;
        int x; int y; int pv; int lk; int er; int fs;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " X"}, int'(X), 0);
        chk({tag, " Y"}, int'(Y), 0);
        chk({tag, " PIX_VALID"}, int'(PIX_VALID), 0);
        chk({tag, " FRAME_START"}, int'(FRAME_START), 0);
        chk({tag, " ACT_W"}, int'(ACT_W), 0);
        chk({tag, " ACT_H"}, int'(ACT_H), 0);
        chk({tag, " H_TOTAL"}, int'(H_TOTAL), 0);
        chk({tag, " V_TOTAL"}, int'(V_TOTAL), 0);
        chk({tag, " LOCKED"}, int'(LOCKED), 0);
        chk({tag, " ERR"}, int'(ERR), 0);
    endtask

`ifdef LCD_RX_FRAME_CRC_EN
    // Independent shift-register form of x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] model_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:12], c[11] ^ fb, c[10:5], c[4] ^ fb, c[3:0], fb};
        end
        return c;
    endfunction
`endif

    // Streams nf frames; bad_line shortens that line of frame 0 to 7 pixels,
    // rst_line pulses reset mid-line in frame 0.
    task automatic run(input int id, input int nf, input int bad_line, input int rst_line,
                       input int exp_errs);
        int errs, fss;
        errs = 0;
        fss  = 0;
        for (int f = 0; f < nf; f++) begin
            for (int l = 0; l < 9; l++) begin
                for (int c = 0; c < 12; c++) begin
                    int wend;
                    wend  = (f == 0 && l == bad_line) ? 9 : 10;
                    HSYNC = !(c < 2);
                    VSYNC = !(l < 2);
                    DE    = (l >= 2 && l <= 7 && c >= 3 && c <= wend);
                    if (f == 0 && l == rst_line && c == 5) begin
                        nRST = 1'b0;
                        #1;
                        chk_zero("async reset");
                    end
                    if (f == 0 && l == rst_line && c == 8) nRST = 1'b1;
`ifdef LCD_RX_FRAME_CRC_EN
                    pix = (id == 2 && f == 1 && l == 2 && c == 3) ? 16'h0000 : 16'hFFFF;
                    {R, G, B} = pix;
                    exp_valid = 1'b0;
                    if (!nRST) begin
                        m_crc   = 16'hFFFF;
                        m_armed = 1'b0;
                    end else begin
                        if (l == 0 && c == 0) begin
                            exp_valid = m_armed;
                            m_frame   = m_crc;
                            m_armed   = 1'b1;
                            m_crc     = 16'hFFFF;
                        end
                        if (DE) m_crc = model_step(m_crc, pix);
                    end
`endif
                    tick();
                    if (ERR) errs++;
                    if (FRAME_START) fss++;
                    for (int k = 0; k < NV; k++) begin
                        if (tbl[k].run == id && tbl[k].f == f && tbl[k].l == l &&
                            tbl[k].c == c) begin
                            string p;
                            p = $sformatf("run%0d f%0d l%0d c%0d", id, f, l, c);
                            chk({p, " X"}, int'(X), tbl[k].x);
                            chk({p, " Y"}, int'(Y), tbl[k].y);
                            chk({p, " PIX_VALID"}, int'(PIX_VALID), tbl[k].pv);
                            chk({p, " LOCKED"}, int'(LOCKED), tbl[k].lk);
                            chk({p, " ERR"}, int'(ERR), tbl[k].er);
                            chk({p, " FRAME_START"}, int'(FRAME_START), tbl[k].fs);
                        end
                    end
`ifdef LCD_RX_FRAME_CRC_EN
                    if (l == 0 && c == 0) begin
                        chk($sformatf("run%0d f%0d CRC_VALID", id, f), int'(CRC_VALID),
                            int'(exp_valid));
                        if (exp_valid) begin
                            chk($sformatf("run%0d f%0d FRAME_CRC", id, f), int'(FRAME_CRC),
                                int'(m_frame));
                            if (id == 1) const_crc = m_frame;
                            if (id == 2 && f == 2)
                                chk("pixel0 change alters FRAME_CRC",
                                    int'(FRAME_CRC != const_crc), 1);
                        end
                    end
`endif
                end
            end
        end
        chk($sformatf("run%0d ERR pulses", id), errs, exp_errs);
        chk($sformatf("run%0d FRAME_START pulses", id), fss, nf);
    endtask

    // VSYNC stuck inactive while lines keep coming.
    task automatic run_sat();
        int errs, first_i, first_c;
        errs    = 0;
        first_i = -1;
        first_c = -1;
        for (int i = 0; i < 2060; i++) begin
            for (int c = 0; c < 12; c++) begin
                int l;
                l     = i % 9;
                HSYNC = !(c < 2);
                VSYNC = 1'b1;
                DE    = (l >= 2 && l <= 7 && c >= 3 && c <= 10);
                tick();
                if (ERR) begin
                    errs++;
                    if (first_i < 0) begin
                        first_i = i;
                        first_c = c;
                    end
                end
            end
        end
        chk("sat ERR pulses", errs, 1);
        chk("sat ERR line", first_i, 2037);
        chk("sat ERR col", first_c, 1);
        chk("sat LOCKED", int'(LOCKED), 0);
        chk("sat state", int'(dut.state), int'(StSearch));
        chk("sat v_cnt", int'(dut.v_cnt), 2047);
        chk("sat ACT_W held", int'(ACT_W), 8);
    endtask

    initial begin
        //          run f  l  c   x  y pv lk er fs
        tbl[0]  = '{1, 0, 2, 3,   0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 2, 10,  7, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 2, 8, 11,  7, 5, 0, 0, 0, 0};
        tbl[3]  = '{1, 3, 0, 0,   7, 5, 0, 1, 0, 1};
        tbl[4]  = '{1, 3, 2, 3,   0, 0, 1, 1, 0, 0};
        tbl[5]  = '{1, 3, 7, 10,  7, 5, 1, 1, 0, 0};
        tbl[6]  = '{1, 3, 7, 11,  7, 5, 0, 1, 0, 0};
        tbl[7]  = '{1, 4, 4, 6,   3, 2, 1, 1, 0, 0};
        tbl[8]  = '{2, 0, 4, 9,   6, 2, 1, 1, 0, 0};
        tbl[9]  = '{2, 0, 4, 10,  6, 2, 0, 0, 1, 0};
        tbl[10] = '{2, 0, 4, 11,  6, 2, 0, 0, 0, 0};
        tbl[11] = '{2, 2, 8, 11,  7, 5, 0, 0, 0, 0};
        tbl[12] = '{2, 3, 0, 0,   7, 5, 0, 1, 0, 1};
        tbl[13] = '{3, 1, 2, 3,   0, 0, 1, 0, 0, 0};
        tbl[14] = '{3, 3, 8, 11,  7, 5, 0, 0, 0, 0};
        tbl[15] = '{3, 4, 0, 0,   7, 5, 0, 1, 0, 1};

        nRST  = 1'b1;
        HSYNC = 1'b1;
        VSYNC = 1'b1;
        DE    = 1'b0;
`ifdef LCD_RX_FRAME_CRC_EN
        {R, G, B} = 16'h0000;
        m_crc     = 16'hFFFF;
        m_frame   = 16'h0000;
        const_crc = 16'h0000;
        m_armed   = 1'b0;
`endif
        #3 nRST = 1'b0;
        #1;
        chk_zero("reset");
        repeat (3) tick();
        nRST = 1'b1;
        repeat (3) tick();

        run(1, 5, -1, -1, 0);
        chk("ACT_W", int'(ACT_W), 8);
        chk("ACT_H", int'(ACT_H), 6);
        chk("H_TOTAL", int'(H_TOTAL), 12);
        chk("V_TOTAL", int'(V_TOTAL), 9);

        run(2, 4, 4, -1, 1);
        run(3, 5, -1, 2, 0);
        chk("post-reset ACT_W", int'(ACT_W), 8);
        chk("post-reset V_TOTAL", int'(V_TOTAL), 9);

        run_sat();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
